// File: rtl/exec_unit_micro.sv
// ---------------------------------------------------------------------------
// exec_unit_micro
//
// Multi-cycle execute stage for the 8-bit micro. On an accepted start it
// drives the register bank select, captures both read operands, computes one
// of eight ALU operations (multiply is an iterative LSB-first shift-add), then
// issues a single-cycle write-back to the destination register and updates
// the flags register.
//
// Ports:
//   clk      in   system clock, rising edge
//   rst      in   asynchronous reset, active-low
//   start    in   operation request, accepted only while busy = 0
//   op       in   opcode: ADD SUB AND OR XOR SHL MUL MOV (000..111)
//   rx_sel   in   first operand / destination register index
//   ry_sel   in   second operand register index
//   Sel_reg  out  bank select {ry, rx}, held from accept until next accept
//   Rx, Ry   in   bank read data for Sel_reg[2:0] / Sel_reg[5:3]
//   W        out  bank write enable, one cycle per operation
//   DW       out  write-back data, valid while W = 1
//   busy     out  operation in progress
//   done     out  completion pulse, coincident with W
//   flags    out  {Z, C, N, V}, updated at the end of write-back
// ---------------------------------------------------------------------------
module exec_unit_micro #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [2:0]       rx_sel,
    input  logic [2:0]       ry_sel,
    output logic [5:0]       Sel_reg,
    input  logic [WIDTH-1:0] Rx,
    input  logic [WIDTH-1:0] Ry,
    output logic             W,
    output logic [WIDTH-1:0] DW,
    output logic             busy,
    output logic             done,
    output logic [3:0]       flags
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam int MSB   = WIDTH - 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SHL = 3'b101;
    localparam logic [2:0] OP_MUL = 3'b110;
    localparam logic [2:0] OP_MOV = 3'b111;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_EXEC,
        S_MUL,
        S_WB
    } state_t;

    state_t state, state_next;

    logic [2:0]         op_q;
    logic [WIDTH-1:0]   op_a, op_b;
    logic [2*WIDTH-1:0] acc, acc_next, partial;
    logic [CNT_W-1:0]   mul_cnt;
    logic [3:0]         flags_pend;   // flags computed ahead, committed in WB

    logic [WIDTH:0]     sum_ext, diff_ext;
    logic [WIDTH-1:0]   alu_res;
    logic               alu_c, alu_v;

    // ---------------- state register ----------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_next;
    end

    // ---------------- next-state logic ----------------
    // NOTE: every combinational output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: if (start) state_next = S_READ;
            S_READ: state_next = (op_q == OP_MUL) ? S_MUL : S_EXEC;
            S_EXEC: state_next = S_WB;
            S_MUL:  if (mul_cnt == LAST_BIT) state_next = S_WB;
            S_WB:   state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    assign busy = (state != S_IDLE);

    // ---------------- single-cycle ALU ----------------
    always_comb begin
        sum_ext  = {1'b0, op_a} + {1'b0, op_b};
        diff_ext = {1'b0, op_a} - {1'b0, op_b};
        alu_res  = '0;
        alu_c    = 1'b0;
        alu_v    = 1'b0;
        case (op_q)
            OP_ADD: begin
                alu_res = sum_ext[WIDTH-1:0];
                alu_c   = sum_ext[WIDTH];
                alu_v   = (op_a[MSB] == op_b[MSB]) && (alu_res[MSB] != op_a[MSB]);
            end
            OP_SUB: begin
                alu_res = diff_ext[WIDTH-1:0];
                alu_c   = diff_ext[WIDTH];   // borrow out == (op_a < op_b)
                alu_v   = (op_a[MSB] != op_b[MSB]) && (alu_res[MSB] != op_a[MSB]);
            end
            OP_AND: alu_res = op_a & op_b;
            OP_OR:  alu_res = op_a | op_b;
            OP_XOR: alu_res = op_a ^ op_b;
            OP_SHL: begin
                alu_res = {op_a[WIDTH-2:0], 1'b0};
                alu_c   = op_a[MSB];
            end
            OP_MOV: alu_res = op_b;
            default: alu_res = '0;   // MUL never completes through EXEC
        endcase
    end

    // ---------------- shift-add multiplier step ----------------
    always_comb begin
        partial  = {{WIDTH{1'b0}}, op_a} << mul_cnt;
        acc_next = op_b[mul_cnt] ? (acc + partial) : acc;
    end

    // ---------------- datapath and outputs ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_q       <= '0;
            Sel_reg    <= '0;
            op_a       <= '0;
            op_b       <= '0;
            acc        <= '0;
            mul_cnt    <= '0;
            flags_pend <= '0;
            flags      <= '0;
            DW         <= '0;
            W          <= 1'b0;
            done       <= 1'b0;
        end else begin
            // Registered strobes: high exactly while the FSM sits in WB.
            W    <= (state_next == S_WB);
            done <= (state_next == S_WB);

            case (state)
                S_IDLE: begin
                    if (start) begin
                        op_q    <= op;
                        Sel_reg <= {ry_sel, rx_sel};
                    end
                end
                S_READ: begin
                    op_a    <= Rx;
                    op_b    <= Ry;
                    acc     <= '0;
                    mul_cnt <= '0;
                end
                S_EXEC: begin
                    DW         <= alu_res;
                    flags_pend <= {(alu_res == '0), alu_c, alu_res[MSB], alu_v};
                end
                S_MUL: begin
                    acc     <= acc_next;
                    mul_cnt <= mul_cnt + 1'b1;
                    if (mul_cnt == LAST_BIT) begin
                        DW         <= acc_next[WIDTH-1:0];
                        flags_pend <= {(acc_next[WIDTH-1:0] == '0),
                                       (acc_next[2*WIDTH-1:WIDTH] != '0),
                                       acc_next[MSB], 1'b0};
                    end
                end
                S_WB: flags <= flags_pend;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_exec_unit_micro.sv
// ---------------------------------------------------------------------------
// tb_exec_unit_micro
//
// Directed bench for exec_unit_micro. A small register bank model closes the
// loop (combinational reads via Sel_reg, write on W at the clock edge) and
// can be preloaded from the stimulus. Expected results are hand-computed.
// ---------------------------------------------------------------------------
module tb_exec_unit_micro;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [2:0] op, rx_sel, ry_sel;
    logic [5:0] Sel_reg;
    logic [7:0] Rx, Ry, DW;
    logic       W, busy, done;
    logic [3:0] flags;

    int checks = 0;
    int errors = 0;
    int w_pulses = 0;

    // register bank model with a preload port
    logic [7:0] bank [8];
    logic       pl_en = 1'b0;
    logic [2:0] pl_idx = '0;
    logic [7:0] pl_val = '0;

    exec_unit_micro #(.WIDTH(8)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .op      (op),
        .rx_sel  (rx_sel),
        .ry_sel  (ry_sel),
        .Sel_reg (Sel_reg),
        .Rx      (Rx),
        .Ry      (Ry),
        .W       (W),
        .DW      (DW),
        .busy    (busy),
        .done    (done),
        .flags   (flags)
    );

    always #5 clk = ~clk;

    assign Rx = bank[Sel_reg[2:0]];
    assign Ry = bank[Sel_reg[5:3]];

    always @(posedge clk) begin
        if (W)     bank[Sel_reg[2:0]] <= DW;
        if (pl_en) bank[pl_idx]       <= pl_val;
        if (W)     w_pulses           <= w_pulses + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_reg(input logic [2:0] idx, input logic [7:0] val);
        @(negedge clk);
        pl_en  = 1'b1;
        pl_idx = idx;
        pl_val = val;
        @(negedge clk);
        pl_en  = 1'b0;
    endtask

    // Issues one operation and checks latency, write-back data, strobes,
    // flags and that exactly one W pulse occurred. Returns at the negedge of
    // the first IDLE cycle after WB. hold keeps start asserted (with other
    // op/selects) through the busy cycles; b2b issues start in that first
    // IDLE cycle of the previous operation.
    task automatic run_op(input string tag, input logic [2:0] o,
                          input logic [2:0] rx, input logic [2:0] ry,
                          input int exp_cyc, input logic [7:0] exp_dw,
                          input logic [3:0] exp_fl, input bit hold, input bit b2b);
        int cyc;
        int w0;
        if (!b2b) @(negedge clk);
        start  = 1'b1;
        op     = o;
        rx_sel = rx;
        ry_sel = ry;
        w0     = w_pulses;
        @(negedge clk);
        cyc = 1;
        if (hold) begin
            op     = 3'b110;
            rx_sel = 3'd7;
            ry_sel = 3'd6;
        end else begin
            start = 1'b0;
        end
        check({tag, " busy c1"}, 16'(busy), 16'h1);
        check({tag, " sel"}, 16'(Sel_reg), 16'({ry, rx}));
        while (W !== 1'b1 && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, " wb cycle"}, 16'(cyc), 16'(exp_cyc));
        check({tag, " DW"}, 16'(DW), 16'(exp_dw));
        check({tag, " done"}, 16'(done), 16'h1);
        @(negedge clk);
        start = 1'b0;
        check({tag, " W after"}, 16'(W), 16'h0);
        check({tag, " busy after"}, 16'(busy), 16'h0);
        check({tag, " flags"}, 16'(flags), 16'(exp_fl));
        check({tag, " sel held"}, 16'(Sel_reg), 16'({ry, rx}));
        check({tag, " W pulses"}, 16'(w_pulses - w0), 16'h1);
    endtask

    initial begin
        int w0;
        for (int i = 0; i < 8; i++) bank[i] = '0;
        rst    = 1'b0;
        start  = 1'b0;
        op     = '0;
        rx_sel = '0;
        ry_sel = '0;
        repeat (3) @(negedge clk);

        // reset state
        check("rst Sel_reg", 16'(Sel_reg), 16'h0);
        check("rst W", 16'(W), 16'h0);
        check("rst DW", 16'(DW), 16'h0);
        check("rst busy", 16'(busy), 16'h0);
        check("rst done", 16'(done), 16'h0);
        check("rst flags", 16'(flags), 16'h0);
        rst = 1'b1;

        // ADD 7F+01 -> 80, signed overflow
        set_reg(3'd1, 8'h7F);
        set_reg(3'd2, 8'h01);
        run_op("add_ovf", 3'b000, 3'd1, 3'd2, 3, 8'h80, 4'b0011, 1'b0, 1'b0);
        check("bank R1 written", 16'(bank[1]), 16'h80);

        // SUB equal -> zero
        set_reg(3'd3, 8'h05);
        set_reg(3'd4, 8'h05);
        run_op("sub_zero", 3'b001, 3'd3, 3'd4, 3, 8'h00, 4'b1000, 1'b0, 1'b0);

        // SUB 03-05 -> FE, borrow
        set_reg(3'd6, 8'h03);
        run_op("sub_borrow", 3'b001, 3'd6, 3'd4, 3, 8'hFE, 4'b0110, 1'b0, 1'b0);

        // SUB 80-01 -> 7F, signed overflow
        set_reg(3'd6, 8'h80);
        set_reg(3'd7, 8'h01);
        run_op("sub_ovf", 3'b001, 3'd6, 3'd7, 3, 8'h7F, 4'b0001, 1'b0, 1'b0);

        // ADD FF+01 with start held high during busy -> ignored
        set_reg(3'd1, 8'hFF);
        set_reg(3'd2, 8'h01);
        run_op("add_carry_hold", 3'b000, 3'd1, 3'd2, 3, 8'h00, 4'b1100, 1'b1, 1'b0);
        repeat (3) @(negedge clk);
        check("hold no extra op busy", 16'(busy), 16'h0);
        check("hold sel unchanged", 16'(Sel_reg), 16'b010001);

        // bitwise ops
        set_reg(3'd6, 8'hF0);
        set_reg(3'd7, 8'h3C);
        run_op("and", 3'b010, 3'd6, 3'd7, 3, 8'h30, 4'b0000, 1'b0, 1'b0);
        set_reg(3'd6, 8'h80);
        set_reg(3'd7, 8'h01);
        run_op("or", 3'b011, 3'd6, 3'd7, 3, 8'h81, 4'b0010, 1'b0, 1'b0);
        set_reg(3'd5, 8'h5A);
        run_op("xor_same", 3'b100, 3'd5, 3'd5, 3, 8'h00, 4'b1000, 1'b0, 1'b0);

        // MUL 10*20 = 0x0200 -> low 00, C=1
        set_reg(3'd1, 8'h10);
        set_reg(3'd2, 8'h20);
        run_op("mul_hi", 3'b110, 3'd1, 3'd2, 10, 8'h00, 4'b1100, 1'b0, 1'b0);

        // MUL 0F*0F = 0x00E1
        set_reg(3'd1, 8'h0F);
        set_reg(3'd2, 8'h0F);
        run_op("mul_e1", 3'b110, 3'd1, 3'd2, 10, 8'hE1, 4'b0010, 1'b0, 1'b0);

        // reset asserted in MUL cycle 5
        set_reg(3'd1, 8'h0F);
        @(negedge clk);
        start  = 1'b1;
        op     = 3'b110;
        rx_sel = 3'd1;
        ry_sel = 3'd2;
        w0     = w_pulses;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        check("mid busy before rst", 16'(busy), 16'h1);
        rst = 1'b0;
        #1;
        check("mid rst W", 16'(W), 16'h0);
        check("mid rst DW", 16'(DW), 16'h0);
        check("mid rst busy", 16'(busy), 16'h0);
        check("mid rst done", 16'(done), 16'h0);
        check("mid rst flags", 16'(flags), 16'h0);
        check("mid rst Sel_reg", 16'(Sel_reg), 16'h0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (8) @(negedge clk);
        check("mid rst no W", 16'(w_pulses - w0), 16'h0);
        check("mid rst R1 intact", 16'(bank[1]), 16'h0F);

        // MOV after reset release
        set_reg(3'd5, 8'hA5);
        run_op("mov", 3'b111, 3'd5, 3'd5, 3, 8'hA5, 4'b0010, 1'b0, 1'b0);

        // SHL then back-to-back ADD reading the just-written value
        set_reg(3'd0, 8'h81);
        run_op("shl", 3'b101, 3'd0, 3'd0, 3, 8'h02, 4'b0100, 1'b0, 1'b0);
        run_op("add_b2b", 3'b000, 3'd0, 3'd0, 3, 8'h04, 4'b0000, 1'b0, 1'b1);
        check("bank R0 final", 16'(bank[0]), 16'h04);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/exec_unit_micro.md
# exec_unit_micro

Multi-cycle execute stage for the 8-bit micro, sitting directly downstream of the 8x8 register bank and closing the loop back into it. On a `start` request it drives the bank's 6-bit register select, captures the two read operands, and computes one of eight ALU operations. Multiply is an iterative shift-add. It then issues a single-cycle write-back (`W`/`DW`) to the destination register and updates a flags register.

## Interface
- `WIDTH`, 8, data width; must match the register bank word width.

- `clk`  in  1  system clock; all state changes on rising edge.
- `rst`  in  1  reset, asynchronous, active-low (0 = reset).
- `start`  in  1  operation request; accepted only while `busy`=0.
- `op`  in  3  opcode, sampled with `start`: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SHL, 110 MUL, 111 MOV.
- `rx_sel`  in  3  first operand and destination register index.
- `ry_sel`  in  3  second operand register index.
- `Sel_reg`  out  6  to bank: {ry_sel latched, rx_sel latched}.
- `Rx`  in  WIDTH  bank read port A (register `Sel_reg[2:0]`), combinational.
- `Ry`  in  WIDTH  bank read port B (register `Sel_reg[5:3]`), combinational.
- `W`  out  1  bank write enable; high for exactly one cycle per operation.
- `DW`  out  WIDTH  write-back data; valid while `W`=1.
- `busy`  out  1  operation in progress.
- `done`  out  1  one-cycle pulse, coincident with `W`.
- `flags`  out  4  {Z,C,N,V}, registered.

## Operation
- FSM states: IDLE, READ, EXEC, MUL, WB. Reset state is IDLE.
- IDLE: `busy`=0. When `start`=1, latch `op`, `rx_sel`, `ry_sel` and go to READ.
- READ: `Sel_reg` carries the latched selects. Capture `Rx`→opA and `Ry`→opB at the end of the cycle. Go to MUL if op=110, otherwise go to EXEC.
- EXEC: compute the result and next flags into registers, then go to WB.
- MUL: 16-bit accumulator, 8 iterations, one multiplier bit per cycle, LSB first. If opB bit i=1, add opA<<i. After the 8th iteration go to WB.
- WB: `W`=1, `done`=1, `DW`=result. `flags` update at the end of this cycle. Then go to IDLE.
- Results, all mod 2^WIDTH:
  - ADD: opA+opB.
  - SUB: opA−opB.
  - AND, OR, XOR: bitwise.
  - SHL: opA<<1, with LSB=0.
  - MUL: low byte of opA·opB.
  - MOV: opB.
- Flags:
  - Z = (result==0).
  - N = result[WIDTH-1].
  - C: ADD carry-out; SUB borrow (opA<opB unsigned); SHL opA[WIDTH-1]; MUL high byte≠0; all others 0.
  - V: signed overflow for ADD/SUB; all others 0.
- `Sel_reg` holds the latched selects from READ through WB, because the bank writes to `Sel_reg[2:0]`. It keeps its value in IDLE until the next accept.
- `start` while `busy`=1 is ignored; no queueing.
- Same register for both operands (rx_sel=ry_sel) is legal.

## Timing
- Reset values: `Sel_reg`=0, `W`=0, `DW`=0, `busy`=0, `done`=0, `flags`=0. The FSM goes to IDLE and internal operands and accumulator clear.
- Cycle 0 is the cycle in which `start`=1 is sampled in IDLE.
- Non-MUL ops:
  - READ in cycle 1, EXEC in cycle 2, WB (`W`=`done`=1) in cycle 3.
  - `busy`=1 in cycles 1–3.
- MUL:
  - READ in cycle 1, MUL in cycles 2–9, WB in cycle 10.
  - `busy`=1 in cycles 1–10.
- Back-to-back: a new `start` is accepted in the first IDLE cycle after WB. The next op then reads the just-written value, since the bank write lands at the end of WB.
- All outputs are registered; `busy` is decoded from the registered state.
- Reset asserted mid-operation clears immediately and asynchronously:
  - `W` drops at once.
  - No partial write-back occurs.
  - `flags` return to 0.
  - After release the block accepts a new `start` normally.

## Test plan
- ADD, R1=0x7F, R2=0x01, rx=1, ry=2 -> `W`=1 in cycle 3, `DW`=0x80, `Sel_reg`=6'b010001, flags Z=0,C=0,N=1,V=1.
- SUB, R3=0x05, R4=0x05 -> `DW`=0x00, Z=1,C=0,N=0,V=0. Then SUB with 0x03−0x05 -> `DW`=0xFE, C=1,N=1.
- MUL, 0x10·0x20 -> `W` in cycle 10, `DW`=0x00, Z=1,C=1. MUL 0x0F·0x0F -> `DW`=0xE1, C=0.
- Second `start` pulsed in cycles 1–3 of an ADD -> ignored: exactly one `W` pulse, `Sel_reg` unchanged until the next accept.
- Reset low during MUL cycle 5 -> all outputs 0 immediately, no `W` pulse. After release, MOV rx=5, ry=5 with R5=0xA5 -> `DW`=0xA5, N=1, `W` in cycle 3.
- SHL R0=0x81, then back-to-back ADD R0+R0 started in the IDLE cycle after WB -> first `DW`=0x02 with C=1; second op reads 0x02 and gives `DW`=0x04.
